// File: rtl/pulse_period_meter.sv
// Pulse period meter: measures the cycle spacing between successive Pulse events and reports
// it as Period, with lock detection (two equal periods in a row) and a sticky loss-of-tick flag.
module pulse_period_meter #(
   parameter int WIDTH = 28
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Pulse,
   input  logic             Clear,
   output logic [WIDTH-1:0] Period,
   output logic             Valid,
   output logic             Locked,
   output logic             Timeout,
   output logic             Measuring
);

   localparam logic [WIDTH-1:0] COUNT_MAX = '1;
   localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

   state_t           state_reg,     state_next;
   logic [WIDTH-1:0] count_reg,     count_next;
   logic [WIDTH-1:0] period_reg,    period_next;
   logic             valid_reg,     valid_next;
   logic             locked_reg,    locked_next;
   logic             timeout_reg,   timeout_next;
   logic             measuring_reg, measuring_next;
   // Set once a period has been measured since the last return to IDLE, so the first
   // measurement after IDLE never reports Locked even if Period still holds a matching value.
   logic             have_prev_reg, have_prev_next;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg     <= IDLE;
         count_reg     <= '0;
         period_reg    <= '0;
         valid_reg     <= 1'b0;
         locked_reg    <= 1'b0;
         timeout_reg   <= 1'b0;
         measuring_reg <= 1'b0;
         have_prev_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         period_reg    <= period_next;
         valid_reg     <= valid_next;
         locked_reg    <= locked_next;
         timeout_reg   <= timeout_next;
         measuring_reg <= measuring_next;
         have_prev_reg <= have_prev_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      period_next    = period_reg;
      valid_next     = 1'b0;
      locked_next    = locked_reg;
      timeout_next   = timeout_reg;
      have_prev_next = have_prev_reg;

      if (Clear) begin
         // Clear outranks Pulse: a coincident event is not taken as a reference.
         state_next     = IDLE;
         count_next     = '0;
         period_next    = '0;
         locked_next    = 1'b0;
         timeout_next   = 1'b0;
         have_prev_next = 1'b0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (Pulse) begin
                  state_next   = MEASURE;
                  count_next   = COUNT_ONE;
                  timeout_next = 1'b0;
               end
            end
            MEASURE: begin
               if (Pulse) begin
                  // An event in the saturation cycle still measures COUNT_MAX.
                  period_next    = count_reg;
                  valid_next     = 1'b1;
                  locked_next    = have_prev_reg && (count_reg == period_reg);
                  have_prev_next = 1'b1;
                  count_next     = COUNT_ONE;
               end else if (count_reg == COUNT_MAX) begin
                  state_next     = IDLE;
                  count_next     = '0;
                  locked_next    = 1'b0;
                  timeout_next   = 1'b1;
                  have_prev_next = 1'b0;
               end else begin
                  count_next = count_reg + COUNT_ONE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end

      measuring_next = (state_next == MEASURE);
   end

   assign Period    = period_reg;
   assign Valid     = valid_reg;
   assign Locked    = locked_reg;
   assign Timeout   = timeout_reg;
   assign Measuring = measuring_reg;

endmodule
